// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: forward pass per layer, optional reverse backprop, a weight
// update every BATCH_SZ training images, and a per-phase watchdog into ERROR.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int BATCH_SZ   = 16,
  parameter int TIMEOUT    = 65536,
  parameter int LBL_W      = 8,
  localparam int LIW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int BCW = $clog2(BATCH_SZ + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             train,
  input  logic             abort,
  input  logic [LBL_W-1:0] label_in,
  input  logic             fp_done,
  input  logic             bp_done,
  input  logic             upd_done,
  input  logic             drawn,
  output logic             do_fp,
  output logic             do_bp,
  output logic             do_upd,
  output logic             draw,
  output logic [LIW-1:0]   layer_idx,
  output logic [LBL_W-1:0] label_out,
  output logic [BCW-1:0]   batch_cnt,
  output logic             busy,
  output logic             ack,
  output logic             err
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LIW-1:0] LAYER_LAST = LIW'(NUM_LAYERS - 1);
  localparam logic [BCW-1:0] BATCH_LAST = BCW'(BATCH_SZ - 1);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);
  localparam bit             WD_EN      = (TIMEOUT > 0);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_UPD, S_DISP, S_ERR} state_t;

  state_t           r_state, w_state_nxt;
  logic [LIW-1:0]   r_layer, w_layer_nxt;
  logic [BCW-1:0]   r_batch, w_batch_nxt;
  logic [LBL_W-1:0] r_label, w_label_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_start_pend, w_start_pend_nxt;
  logic             r_train_pend, w_train_pend_nxt;
  logic             r_err, w_err_nxt;
  logic             r_do_fp, r_do_bp, r_do_upd, r_draw, r_ack, r_busy;
  logic             w_fp, w_bp, w_upd, w_draw, w_ack;
  logic [WDW-1:0]   r_wd;
  logic             w_expire, w_active, w_go;

  assign w_active = (r_state == S_FWD) || (r_state == S_BWD) ||
                    (r_state == S_UPD) || (r_state == S_DISP);
  // Expiry is judged on the cycle the count would reach TIMEOUT, so a done in
  // that same cycle is still honoured by the branches below.
  assign w_expire = WD_EN && w_active && (r_wd == WD_LAST);
  assign w_go     = w_fp | w_bp | w_upd | w_draw;

  always_comb begin
    w_state_nxt      = r_state;
    w_layer_nxt      = r_layer;
    w_batch_nxt      = r_batch;
    w_label_nxt      = r_label;
    w_mode_nxt       = r_mode;
    w_start_pend_nxt = r_start_pend | start;
    w_train_pend_nxt = r_train_pend | train;
    w_err_nxt        = r_err;
    w_fp             = 1'b0;
    w_bp             = 1'b0;
    w_upd            = 1'b0;
    w_draw           = 1'b0;
    w_ack            = 1'b0;
    if (abort) begin
      w_state_nxt      = S_IDLE;
      w_err_nxt        = 1'b0;
      w_start_pend_nxt = 1'b0;
      w_train_pend_nxt = 1'b0;
      w_batch_nxt      = '0;
      w_layer_nxt      = '0;
    end else begin
      case (r_state)
        S_IDLE: if (start || r_start_pend) begin
          w_state_nxt      = S_FWD;
          w_layer_nxt      = '0;
          w_fp             = 1'b1;
          w_label_nxt      = label_in;
          w_mode_nxt       = train | r_train_pend;
          // A start seen alongside an already-pending one queues another pass.
          w_start_pend_nxt = r_start_pend & start;
          w_train_pend_nxt = 1'b0;
        end
        S_FWD: if (fp_done) begin
          if (r_layer < LAYER_LAST) begin
            w_layer_nxt = r_layer + 1'b1;
            w_fp        = 1'b1;
          end else if (r_mode) begin
            w_state_nxt = S_BWD;
            w_layer_nxt = LAYER_LAST;
            w_bp        = 1'b1;
          end else begin
            w_state_nxt = S_DISP;
            w_draw      = 1'b1;
          end
        end else if (w_expire) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end
        S_BWD: if (bp_done) begin
          if (r_layer != '0) begin
            w_layer_nxt = r_layer - 1'b1;
            w_bp        = 1'b1;
          end else if (r_batch == BATCH_LAST) begin
            w_batch_nxt = '0;
            w_state_nxt = S_UPD;
            w_upd       = 1'b1;
          end else begin
            w_batch_nxt = r_batch + 1'b1;
            w_state_nxt = S_IDLE;
            w_ack       = 1'b1;
          end
        end else if (w_expire) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end
        S_UPD: if (upd_done) begin
          w_state_nxt = S_IDLE;
          w_layer_nxt = '0;
          w_ack       = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end
        S_DISP: if (drawn) begin
          w_state_nxt = S_IDLE;
          w_ack       = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end
        S_ERR: begin
          w_start_pend_nxt = r_start_pend;
          w_train_pend_nxt = r_train_pend;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_batch      <= '0;
      r_label      <= '0;
      r_mode       <= 1'b0;
      r_start_pend <= 1'b0;
      r_train_pend <= 1'b0;
      r_err        <= 1'b0;
      r_do_fp      <= 1'b0;
      r_do_bp      <= 1'b0;
      r_do_upd     <= 1'b0;
      r_draw       <= 1'b0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_layer      <= w_layer_nxt;
      r_batch      <= w_batch_nxt;
      r_label      <= w_label_nxt;
      r_mode       <= w_mode_nxt;
      r_start_pend <= w_start_pend_nxt;
      r_train_pend <= w_train_pend_nxt;
      r_err        <= w_err_nxt;
      r_do_fp      <= w_fp;
      r_do_bp      <= w_bp;
      r_do_upd     <= w_upd;
      r_draw       <= w_draw;
      r_ack        <= w_ack;
      r_busy       <= (w_state_nxt != S_IDLE);
      if (abort || w_go) r_wd <= '0;
      else if (w_active) r_wd <= r_wd + 1'b1;
    end
  end

  assign do_fp     = r_do_fp;
  assign do_bp     = r_do_bp;
  assign do_upd    = r_do_upd;
  assign draw      = r_draw;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign err       = r_err;
  assign layer_idx = r_layer;
  assign label_out = r_label;
  assign batch_cnt = r_batch;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench: a pass-level model builds the expected go/ack sequence for
// each image and checks the sequencer cycle by cycle.
module tb_nn_layer_sequencer;
  localparam int NL = 2, BS = 2, TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 0, train0 = 0, abort0 = 0;
  logic       fp_done0 = 0, bp_done0 = 0, upd_done0 = 0, drawn0 = 0;
  logic [7:0] label0 = 0, label_out0;
  logic       do_fp0, do_bp0, do_upd0, draw0, busy0, ack0, err0;
  logic [0:0] layer0;
  logic [1:0] batch0;

  logic       start1 = 0, train1 = 0, abort1 = 0;
  logic       fp_done1 = 0, bp_done1 = 0, upd_done1 = 0, drawn1 = 0;
  logic [7:0] label1 = 0, label_out1;
  logic       do_fp1, do_bp1, do_upd1, draw1, busy1, ack1, err1;
  logic [0:0] layer1;
  logic [0:0] batch1;

  nn_layer_sequencer #(.NUM_LAYERS(NL), .BATCH_SZ(BS), .TIMEOUT(TO), .LBL_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .train(train0), .abort(abort0),
    .label_in(label0), .fp_done(fp_done0), .bp_done(bp_done0), .upd_done(upd_done0),
    .drawn(drawn0), .do_fp(do_fp0), .do_bp(do_bp0), .do_upd(do_upd0), .draw(draw0),
    .layer_idx(layer0), .label_out(label_out0), .batch_cnt(batch0), .busy(busy0),
    .ack(ack0), .err(err0));

  nn_layer_sequencer #(.NUM_LAYERS(1), .BATCH_SZ(1), .TIMEOUT(TO), .LBL_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .train(train1), .abort(abort1),
    .label_in(label1), .fp_done(fp_done1), .bp_done(bp_done1), .upd_done(upd_done1),
    .drawn(drawn1), .do_fp(do_fp1), .do_bp(do_bp1), .do_upd(do_upd1), .draw(draw1),
    .layer_idx(layer1), .label_out(label_out1), .batch_cnt(batch1), .busy(busy1),
    .ack(ack1), .err(err1));

  typedef struct { logic [4:0] pv; int lyr; } ev_t;

  int checks = 0, errors = 0;
  int m_batch = 0;

  localparam logic [4:0] P_FP = 5'b10000, P_BP = 5'b01000, P_UPD = 5'b00100,
                         P_DRAW = 5'b00010, P_ACK = 5'b00001, P_NONE = 5'b00000;

  function automatic logic [4:0] pv0();
    return {do_fp0, do_bp0, do_upd0, draw0, ack0};
  endfunction

  function automatic logic [4:0] pv1();
    return {do_fp1, do_bp1, do_upd1, draw1, ack1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One image pass on DUT0: expected events come from the model, random gaps
  // before each done, optional extra start pulses during the first events.
  task automatic run_pass(input bit tr, input logic [7:0] lbl, input bit launch,
                          input int n_starts);
    ev_t evs[$];
    int  d;
    for (int l = 0; l < NL; l++) evs.push_back('{P_FP, l});
    if (tr) begin
      for (int l = NL - 1; l >= 0; l--) evs.push_back('{P_BP, l});
      if (m_batch == BS - 1) begin
        evs.push_back('{P_UPD, 0});
        m_batch = 0;
      end else m_batch++;
    end else evs.push_back('{P_DRAW, NL - 1});
    evs.push_back('{P_ACK, -1});
    label0 = lbl; start0 = launch; train0 = tr;
    tick();
    start0 = 0; train0 = 0;
    for (int i = 0; i < evs.size(); i++) begin
      checks++;
      if (pv0() !== evs[i].pv || (evs[i].lyr >= 0 && layer0 !== 1'(evs[i].lyr))) begin
        errors++;
        $display("FAIL pass_event%0d: got pulses=%b layer=%0d, want pulses=%b layer=%0d",
                 i, pv0(), layer0, evs[i].pv, evs[i].lyr);
      end
      if (i < evs.size() - 1) begin
        d = int'($urandom_range(0, 4));
        if (i < n_starts && d == 0) d = 1;
        for (int k = 0; k < d; k++) begin
          if (i < n_starts && k == 0) start0 = 1;
          tick();
          start0 = 0;
          checks++;
          if (pv0() !== P_NONE || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL pass_quiet: got pulses=%b busy=%b, want pulses=00000 busy=1", pv0(), busy0);
          end
        end
        case (evs[i].pv)
          P_FP:    fp_done0  = 1;
          P_BP:    bp_done0  = 1;
          P_UPD:   upd_done0 = 1;
          default: drawn0    = 1;
        endcase
        tick();
        fp_done0 = 0; bp_done0 = 0; upd_done0 = 0; drawn0 = 0;
      end
    end
    checks++;
    if (busy0 !== 1'b0 || label_out0 !== lbl || batch0 !== 2'(m_batch) || err0 !== 1'b0) begin
      errors++;
      $display("FAIL pass_end: got busy=%b label=%h batch=%0d err=%b, want busy=0 label=%h batch=%0d err=0",
               busy0, label_out0, batch0, err0, lbl, m_batch);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({pv0(), busy0, err0, layer0, batch0, label_out0} !== '0 ||
        {pv1(), busy1, err1, layer1, batch1, label_out1} !== '0) begin
      errors++;
      $display("FAIL reset_state: dut0 pulses=%b busy=%b err=%b, dut1 pulses=%b busy=%b err=%b, want all 0",
               pv0(), busy0, err0, pv1(), busy1, err1);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (pv0() !== P_NONE || busy0 !== 1'b0 || pv1() !== P_NONE || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: pulses0=%b busy0=%b pulses1=%b busy1=%b, want 0", pv0(), busy0, pv1(), busy1);
    end
  endtask

  task automatic test_infer();
    run_pass(1'b0, 8'h07, 1'b1, 0);
  endtask

  task automatic test_train_batch();
    run_pass(1'b1, 8'($urandom), 1'b1, 0);
    run_pass(1'b1, 8'($urandom), 1'b1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) run_pass(1'($urandom), 8'($urandom), 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_pass(1'b0, 8'h3c, 1'b1, 3);
    run_pass(1'b0, 8'hc3, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pv0() !== P_NONE || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL no_extra_launch: got pulses=%b busy=%b, want 00000 busy=0", pv0(), busy0);
      end
    end
  endtask

  task automatic test_timeout();
    if (m_batch == 0) run_pass(1'b1, 8'h11, 1'b1, 0);
    start0 = 1; label0 = 8'h5a;
    tick();
    start0 = 0;
    checks++;
    if (pv0() !== P_FP) begin
      errors++;
      $display("FAIL wd_launch: got pulses=%b, want 10000", pv0());
    end
    for (int k = 1; k <= TO; k++) begin
      tick();
      checks++;
      if (err0 !== (k == TO) || pv0() !== P_NONE) begin
        errors++;
        $display("FAIL wd_count%0d: got err=%b pulses=%b, want err=%b pulses=00000", k, err0, pv0(), k == TO);
      end
    end
    start0 = 1; fp_done0 = 1;
    tick();
    start0 = 0; fp_done0 = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (err0 !== 1'b1 || busy0 !== 1'b1 || pv0() !== P_NONE) begin
        errors++;
        $display("FAIL err_hold: got err=%b busy=%b pulses=%b, want err=1 busy=1 00000", err0, busy0, pv0());
      end
    end
    abort0 = 1;
    tick();
    abort0 = 0;
    m_batch = 0;
    checks++;
    if (err0 !== 1'b0 || busy0 !== 1'b0 || batch0 !== 2'd0 || layer0 !== 1'b0 || pv0() !== P_NONE) begin
      errors++;
      $display("FAIL abort: got err=%b busy=%b batch=%0d layer=%0d pulses=%b, want all 0",
               err0, busy0, batch0, layer0, pv0());
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (busy0 !== 1'b0 || pv0() !== P_NONE) begin
        errors++;
        $display("FAIL abort_idle: got busy=%b pulses=%b, want busy=0 00000", busy0, pv0());
      end
    end
  endtask

  task automatic test_expiry_done();
    start0 = 1; label0 = 8'h99;
    tick();
    start0 = 0;
    for (int k = 1; k < TO; k++) tick();
    fp_done0 = 1;
    tick();
    fp_done0 = 0;
    checks++;
    if (pv0() !== P_FP || layer0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL expiry_done: got pulses=%b layer=%0d err=%b, want 10000 layer=1 err=0", pv0(), layer0, err0);
    end
    fp_done0 = 1;
    tick();
    fp_done0 = 0;
    drawn0 = 1;
    tick();
    drawn0 = 0;
    checks++;
    if (pv0() !== P_ACK || err0 !== 1'b0 || label_out0 !== 8'h99) begin
      errors++;
      $display("FAIL expiry_ack: got pulses=%b err=%b label=%h, want 00001 err=0 label=99", pv0(), err0, label_out0);
    end
  endtask

  task automatic test_single_layer();
    logic [4:0] exp_seq [4];
    logic [7:0] lbl;
    exp_seq = '{P_FP, P_BP, P_UPD, P_ACK};
    for (int p = 0; p < 2; p++) begin
      lbl = 8'($urandom);
      start1 = 1; train1 = 1; label1 = lbl;
      tick();
      start1 = 0; train1 = 0;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pv1() !== exp_seq[i] || layer1 !== 1'b0 || batch1 !== 1'b0) begin
          errors++;
          $display("FAIL single_layer%0d_%0d: got pulses=%b layer=%0d batch=%0d, want %b layer=0 batch=0",
                   p, i, pv1(), layer1, batch1, exp_seq[i]);
        end
        if (i == 0) fp_done1 = 1;
        if (i == 1) bp_done1 = 1;
        if (i == 2) upd_done1 = 1;
        if (i < 3) begin
          tick();
          fp_done1 = 0; bp_done1 = 0; upd_done1 = 0;
        end
      end
      checks++;
      if (busy1 !== 1'b0 || label_out1 !== lbl) begin
        errors++;
        $display("FAIL single_layer_end: got busy=%b label=%h, want busy=0 label=%h", busy1, label_out1, lbl);
      end
    end
  endtask

  task automatic test_async_reset();
    start0 = 1; train0 = 1; label0 = 8'hee;
    tick();
    start0 = 0; train0 = 0;
    fp_done0 = 1;
    tick();
    tick();
    fp_done0 = 0;
    checks++;
    if (pv0() !== P_BP || layer0 !== 1'b1) begin
      errors++;
      $display("FAIL bwd_entry: got pulses=%b layer=%0d, want 01000 layer=1", pv0(), layer0);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({pv0(), busy0, err0, layer0, batch0, label_out0} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pulses=%b busy=%b layer=%0d batch=%0d label=%h, want all 0",
               pv0(), busy0, layer0, batch0, label_out0);
    end
    m_batch = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_infer();
    test_train_batch();
    test_random();
    test_back_to_back();
    test_timeout();
    test_expiry_done();
    test_single_layer();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
